// File: rtl/loopback_pkg.sv
// Shared types and the per-call transform for the loopback pipe.
//   mode_t    : 2-bit transform select carried with each call
//   lb_xform  : applies a transform to a value of up to LB_MAX_W bits; callers
//               zero-extend their operands and truncate the result back to
//               their own width, so only the rotate needs the real width.
package loopback_pkg;

  typedef enum logic [1:0] {
    MODE_PASS = 2'd0,
    MODE_ADD  = 2'd1,
    MODE_INV  = 2'd2,
    MODE_ROL  = 2'd3
  } mode_t;

  // Widest data path the shared transform supports.
  localparam int unsigned LB_MAX_W = 64;

  function automatic logic [LB_MAX_W-1:0] lb_xform(
    input mode_t                mode,
    input logic [LB_MAX_W-1:0]  idx,
    input logic [LB_MAX_W-1:0]  offset,
    input int unsigned          width
  );
    logic [LB_MAX_W-1:0] r;
    r = idx;
    case (mode)
      MODE_PASS: r = idx;
      MODE_ADD:  r = idx + offset;
      MODE_INV:  r = ~idx;
      // idx is zero-extended, so the MSB shifted out lands above the caller's
      // width (dropped by truncation) and the right shift brings it to bit 0.
      MODE_ROL:  r = (idx << 1) | (idx >> (width - 1));
    endcase
    return r;
  endfunction

endpackage

// File: rtl/loopback_fifo.sv
// First-word-fall-through synchronous FIFO, DEPTH entries, any DEPTH >= 1.
//   clk, rst_n : clock, asynchronous active-low reset
//   push/wdata : write one entry (must not be full)
//   pop        : discard the head entry (must not be empty)
//   rdata      : head entry, reads 0 while empty
//   empty/full : occupancy flags
//   count      : number of stored entries, 0..DEPTH
module loopback_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         push,
  input  logic [WIDTH-1:0]             wdata,
  input  logic                         pop,
  output logic [WIDTH-1:0]             rdata,
  output logic                         empty,
  output logic                         full,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int unsigned   PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned   CW   = $clog2(DEPTH+1);
  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;

  // Explicit wrap so DEPTH need not be a power of two.
  function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
    return (p == LAST) ? '0 : p + PW'(1);
  endfunction

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= bump(wr_ptr);
      if (pop)  rd_ptr <= bump(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: ;
      endcase
    end
  end

  // NOTE: the storage array has no reset; entries are only read once count
  // says they were written, so resetting them would only cost flops.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wdata;
  end

  assign empty = (count == '0);
  assign full  = (count == CW'(DEPTH));
  assign rdata = empty ? '0 : mem[rd_ptr];

  a_no_overflow:  assert property (@(posedge clk) disable iff (!rst_n) !(push && full));
  a_no_underflow: assert property (@(posedge clk) disable iff (!rst_n) !(pop && empty));

endmodule

// File: rtl/loopback_pipe.sv
// Pipelined loopback probe between an HLS call and return interface.
// Calls (start/idx/mode) are accepted every cycle while credits remain, the
// transform is applied in stage 1, stages 2..LATENCY only delay, and results
// leave in order through a FWFT FIFO. The credit counter covers both the
// pipeline and the FIFO, so the pipeline never has to stall.
//   clock, resetn : clock, asynchronous active-low reset
//   start, idx    : call valid and data; mode selects the transform
//   busy          : call stall; a call is accepted iff start && !busy
//   done          : return valid (FIFO not empty); returndata is the head
//   stall         : return stall; head popped iff done && !stall
//   idle          : no calls outstanding
// WIDTH must not exceed loopback_pkg::LB_MAX_W.
module loopback_pipe
  import loopback_pkg::*;
#(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned LATENCY = 2,
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned OFFSET  = 1
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             start,
  input  logic [WIDTH-1:0] idx,
  input  logic [1:0]       mode,
  output logic             busy,
  output logic             done,
  input  logic             stall,
  output logic [WIDTH-1:0] returndata,
  output logic             idle
);

  localparam int unsigned CW = $clog2(DEPTH+1);

  logic [CW-1:0]                  cnt_q;
  logic [CW-1:0]                  cnt_d;
  logic                           accept;
  logic                           pop;
  logic                           push;
  logic [WIDTH-1:0]               stage_in;
  logic [LATENCY-1:0]             valid_q;
  logic [LATENCY-1:0][WIDTH-1:0]  data_q;
  logic                           fifo_empty;
  logic                           fifo_full;
  logic [CW-1:0]                  fifo_count;

  // busy comes from the registered count only, so a pop frees its slot one
  // cycle later and there is no combinational path from stall to busy.
  assign busy   = (cnt_q == CW'(DEPTH));
  assign idle   = (cnt_q == '0);
  assign accept = start && !busy;
  assign done   = !fifo_empty;
  assign pop    = done && !stall;
  assign push   = valid_q[LATENCY-1];

  always_comb begin
    // NOTE: cnt_d gets its default before any branch, so no path leaves it
    // unassigned and no latch is inferred.
    cnt_d = cnt_q;
    case ({accept, pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: ;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  assign stage_in = WIDTH'(lb_xform(mode_t'(mode), LB_MAX_W'(idx), LB_MAX_W'(OFFSET), WIDTH));

  // Stage 1 captures the transformed value; later stages are a plain shift.
  // The valid bits are reset so a call in flight at reset is dropped.
  if (LATENCY == 1) begin : g_lat1
    always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) valid_q <= '0;
      else         valid_q <= accept;
    end
    always_ff @(posedge clock) begin
      data_q <= stage_in;
    end
  end else begin : g_latn
    always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) valid_q <= '0;
      else         valid_q <= {valid_q[LATENCY-2:0], accept};
    end
    always_ff @(posedge clock) begin
      data_q <= {data_q[LATENCY-2:0], stage_in};
    end
  end

  loopback_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clock),
    .rst_n (resetn),
    .push  (push),
    .wdata (data_q[LATENCY-1]),
    .pop   (pop),
    .rdata (returndata),
    .empty (fifo_empty),
    .full  (fifo_full),
    .count (fifo_count)
  );

  a_cnt_range:    assert property (@(posedge clock) disable iff (!resetn) cnt_q <= CW'(DEPTH));
  a_credit_cover: assert property (@(posedge clock) disable iff (!resetn) cnt_q >= fifo_count);
  a_full_busy:    assert property (@(posedge clock) disable iff (!resetn) fifo_full |-> busy);

endmodule

// File: tb/tb_loopback_pipe.sv
// Self-checking bench for loopback_pipe: directed sequences on the default
// configuration, randomized traffic on a DEPTH=3 / LATENCY=1 instance.
module tb_loopback_pipe;

  logic        clock;
  logic        resetn;

  // Default instance: WIDTH=32, LATENCY=2, DEPTH=4, OFFSET=1.
  logic        start, busy, done, stall, idle;
  logic [31:0] idx, returndata;
  logic [1:0]  mode;

  // Random-traffic instance: LATENCY=1, DEPTH=3.
  localparam int R_DEPTH = 3;
  localparam int R_LAT   = 1;
  logic        r_start, r_busy, r_done, r_stall, r_idle;
  logic [31:0] r_idx, r_returndata;
  logic [1:0]  r_mode;

  int n_tot = 0;
  int n_bad = 0;

  loopback_pipe dut (
    .clock(clock), .resetn(resetn), .start(start), .idx(idx), .mode(mode),
    .busy(busy), .done(done), .stall(stall), .returndata(returndata), .idle(idle)
  );

  loopback_pipe #(.WIDTH(32), .LATENCY(R_LAT), .DEPTH(R_DEPTH), .OFFSET(1)) dut_r (
    .clock(clock), .resetn(resetn), .start(r_start), .idx(r_idx), .mode(r_mode),
    .busy(r_busy), .done(r_done), .stall(r_stall), .returndata(r_returndata), .idle(r_idle)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tot++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Reference transform straight from the mode definitions.
  function automatic logic [31:0] ref_xform(input logic [1:0] m, input logic [31:0] v);
    case (m)
      2'd0:    return v;
      2'd1:    return v + 32'd1;
      2'd2:    return ~v;
      default: return {v[30:0], v[31]};
    endcase
  endfunction

  typedef struct {
    logic [1:0]  mode;
    logic [31:0] idx;
    logic [31:0] exp;
  } vec_t;

  typedef struct {
    logic [31:0] val;
    int          ready;
  } exp_t;

  vec_t vecs[8];
  exp_t mq[$];
  logic [31:0] t3_exp[$];

  initial begin
    vecs[0] = '{2'd0, 32'h0000_0001, 32'h0000_0001};
    vecs[1] = '{2'd1, 32'h0000_0002, 32'h0000_0003};
    vecs[2] = '{2'd2, 32'h0000_0003, 32'hFFFF_FFFC};
    vecs[3] = '{2'd3, 32'h0000_0004, 32'h0000_0008};
    vecs[4] = '{2'd1, 32'hFFFF_FFFF, 32'h0000_0000};
    vecs[5] = '{2'd3, 32'h8000_0000, 32'h0000_0001};
    vecs[6] = '{2'd2, 32'hA5A5_A5A5, 32'h5A5A_5A5A};
    vecs[7] = '{2'd3, 32'hC000_0001, 32'h8000_0003};

    resetn = 1'b0;
    start = 1'b0; idx = '0; mode = 2'd0; stall = 1'b0;
    r_start = 1'b0; r_idx = '0; r_mode = 2'd0; r_stall = 1'b0;

    // ---- reset state
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_idle", idle, 1);
    check("rst_data", returndata, 0);
    tick(); tick();
    resetn = 1'b1;
    tick();
    check("rst_idle_after", idle, 1);

    // ---- single call, latency 2
    start = 1'b1; idx = 32'd5; mode = 2'd0;
    tick();                                   // accept edge k
    start = 1'b0;
    check("t1_done_k", done, 0);
    check("t1_idle_k", idle, 0);
    tick();
    check("t1_done_k1", done, 0);
    tick();
    check("t1_done_k2", done, 1);
    check("t1_data", returndata, 5);
    tick();                                   // popped
    check("t1_done_after", done, 0);
    check("t1_idle_after", idle, 1);

    // ---- back-to-back table: done expected in samples 3..N+2, in order
    begin
      int ret = 0;
      for (int c = 0; c < 13; c++) begin
        check("t2_busy", busy, 0);
        check("t2_done_window", done, (c >= 3 && c <= 10));
        if (done && ret < 8) begin
          check($sformatf("t2_data_%0d", ret), returndata, vecs[ret].exp);
          ret++;
        end
        if (c < 8) begin
          start = 1'b1; idx = vecs[c].idx; mode = vecs[c].mode;
        end else begin
          start = 1'b0;
        end
        tick();
      end
      check("t2_count", ret, 8);
      check("t2_idle", idle, 1);
    end

    // ---- fill under stall, free one slot, re-accept
    begin
      int acc = 0;
      stall = 1'b1; start = 1'b1; mode = 2'd0;
      for (int c = 0; c < 8; c++) begin
        idx = 32'd16 + 32'(c);
        if (!busy) begin
          acc++;
          t3_exp.push_back(idx);
        end
        tick();
      end
      check("t3_accepts", acc, 4);
      check("t3_busy", busy, 1);
      check("t3_done", done, 1);
      check("t3_head_stable", returndata, 16);
      void'(t3_exp.pop_front());
      idx = 32'd99;
      stall = 1'b0;
      tick();                                 // pop edge; start ignored here
      stall = 1'b1;
      check("t3_freed", busy, 0);
      check("t3_next_head", returndata, 17);
      tick();                                 // accepts 99
      start = 1'b0;
      t3_exp.push_back(32'd99);
      check("t3_reaccept_busy", busy, 1);
      stall = 1'b0;
      begin
        int got = 0;
        for (int c = 0; c < 12 && got < 4; c++) begin
          if (done) begin
            check($sformatf("t3_drain_%0d", got), returndata, t3_exp[got]);
            got++;
          end
          tick();
        end
        check("t3_drained", got, 4);
      end
      check("t3_idle", idle, 1);
    end

    // ---- reset with three calls outstanding
    stall = 1'b1; start = 1'b1; mode = 2'd0;
    for (int i = 0; i < 3; i++) begin
      idx = 32'h100 + 32'(i);
      tick();
    end
    start = 1'b0;
    check("t5_pre_done", done, 1);
    check("t5_pre_idle", idle, 0);
    #1 resetn = 1'b0;
    #1;
    check("t5_done", done, 0);
    check("t5_busy", busy, 0);
    check("t5_idle", idle, 1);
    #1 resetn = 1'b1;
    stall = 1'b0;
    tick();
    start = 1'b1; idx = 32'h77; mode = 2'd1;
    tick();
    start = 1'b0;
    for (int c = 0; c < 8 && !done; c++) tick();
    check("t5_new_done", done, 1);
    check("t5_new_data", returndata, 32'h78);
    tick();
    for (int c = 0; c < 4; c++) begin
      check("t5_no_stale", done, 0);
      tick();
    end
    check("t5_idle_end", idle, 1);

    // ---- randomized traffic against the queue model (DEPTH=3, LATENCY=1)
    begin
      int  cyc = 0;
      int  n_acc = 0;
      int  bad0 = n_bad;
      bit  m_busy, m_done;
      while ((n_acc < 10000 || mq.size() > 0) && cyc < 60000 && (n_bad - bad0) < 20) begin
        m_busy = (mq.size() == R_DEPTH);
        m_done = (mq.size() > 0) && (mq[0].ready <= cyc);
        check("t6_busy", r_busy, m_busy);
        check("t6_idle", r_idle, (mq.size() == 0));
        check("t6_done", r_done, m_done);
        if (m_done && r_done) check("t6_data", r_returndata, mq[0].val);
        r_start = (n_acc < 10000) ? 1'($urandom_range(0, 1)) : 1'b0;
        r_stall = 1'($urandom_range(0, 1));
        r_idx   = $urandom;
        r_mode  = 2'($urandom_range(0, 3));
        if (m_done && !r_stall) void'(mq.pop_front());
        if (r_start && !m_busy) begin
          mq.push_back('{val: ref_xform(r_mode, r_idx), ready: cyc + 1 + R_LAT});
          n_acc++;
        end
        tick();
        cyc++;
      end
      r_start = 1'b0;
      check("t6_calls", n_acc, 10000);
      check("t6_drained", mq.size(), 0);
      check("t6_idle_end", r_idle, 1);
    end

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule
